// File: rtl/boreal_action_gate_if.sv
// Action-request, executor and MMIO signals of the action gate.
// master = VM / executor / bus side, slave = the gate.
interface boreal_action_gate_if;
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    logic        act_valid;
    logic [31:0] act_opcode;
    logic [31:0] act_target;
    logic [31:0] act_arg0;
    logic [31:0] act_arg1;
    logic [31:0] act_context_hash;
    logic [31:0] act_policy_hash;
    logic [31:0] act_bounds;
    logic [31:0] act_nonce;
    logic        act_ready;

    logic        exec_valid;
    logic [31:0] exec_opcode;
    logic [31:0] exec_target;
    logic [31:0] exec_arg0;
    logic [31:0] exec_arg1;
    logic        exec_ready;

    logic        verdict_valid;
    logic [2:0]  verdict_reason;

    modport master (
        output sel, wr, addr, wdata,
        output act_valid, act_opcode, act_target, act_arg0, act_arg1,
        output act_context_hash, act_policy_hash, act_bounds, act_nonce,
        output exec_ready,
        input  rdata, ack, act_ready,
        input  exec_valid, exec_opcode, exec_target, exec_arg0, exec_arg1,
        input  verdict_valid, verdict_reason
    );

    modport slave (
        input  sel, wr, addr, wdata,
        input  act_valid, act_opcode, act_target, act_arg0, act_arg1,
        input  act_context_hash, act_policy_hash, act_bounds, act_nonce,
        input  exec_ready,
        output rdata, ack, act_ready,
        output exec_valid, exec_opcode, exec_target, exec_arg0, exec_arg1,
        output verdict_valid, verdict_reason
    );
endinterface

// File: rtl/boreal_action_gate.sv
// Policy gate between the decision VM and the executor: checks one action at a time
// against MMIO policy, forwards passing actions with a timeout, logs verdicts.
//   state | meaning
//   IDLE  | act_ready high, waiting for an armed request
//   CHECK | evaluate policy on latched fields
//   EXEC  | exec_valid held until exec_ready or timeout
//   DONE  | one-cycle turnaround before act_ready returns
module boreal_action_gate #(
    parameter int unsigned EXEC_TIMEOUT = 256,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    boreal_action_gate_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned      TMR_W    = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(EXEC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic             armed;
    logic [TMR_W-1:0] tmr;

    logic             ctrl_enable;
    logic             ctrl_nonce;
    logic [15:0]      opc_allow;
    logic [31:0]      tgt_lo;
    logic [31:0]      tgt_hi;
    logic [31:0]      arg_max;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] reject_cnt;
    logic [31:0]      last_nonce;
    logic [2:0]       last_reason;

    logic [31:0] lat_opcode, lat_target, lat_arg0, lat_arg1;
    logic [31:0] lat_context_hash, lat_policy_hash, lat_bounds, lat_nonce;

    logic        act_ready_q;
    logic        exec_valid_q;
    logic [31:0] exec_opcode_q, exec_target_q, exec_arg0_q, exec_arg1_q;
    logic        verdict_valid_q;
    logic [2:0]  verdict_reason_q;

    logic        mmio_wr;
    logic [7:0]  off;
    logic        clr_cnt;
    logic        accept;
    logic        inc_acc;
    logic        inc_rej;
    logic [2:0]  chk_reason;
    logic [31:0] rdata_c;
    logic        unused_bits;

    assign mmio_wr = bus.sel & bus.wr;
    assign off     = bus.addr[7:0];
    assign clr_cnt = mmio_wr && (off == 8'h00) && bus.wdata[2];
    assign accept  = (state == ST_IDLE) && armed && bus.act_valid;
    assign inc_acc = (state == ST_EXEC) && bus.exec_ready;
    assign inc_rej = ((state == ST_CHECK) && (chk_reason != 3'd0)) ||
                     ((state == ST_EXEC) && !bus.exec_ready && (tmr == '0));

    // Hashes and bounds are captured with the request but not part of the policy yet.
    assign unused_bits = ^{lat_context_hash, lat_policy_hash, lat_bounds, bus.addr[31:8]};

    always_comb begin
        chk_reason = 3'd0;
        if (!ctrl_enable)
            chk_reason = 3'd1;
        else if ((lat_opcode > 32'd15) || !opc_allow[lat_opcode[3:0]])
            chk_reason = 3'd2;
        else if ((lat_target < tgt_lo) || (lat_target > tgt_hi))
            chk_reason = 3'd3;
        else if (lat_arg0 > arg_max)
            chk_reason = 3'd4;
        else if (ctrl_nonce && (lat_nonce <= last_nonce))
            chk_reason = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_enable <= 1'b0;
            ctrl_nonce  <= 1'b0;
            opc_allow   <= 16'h0000;
            tgt_lo      <= 32'h0000_0000;
            tgt_hi      <= 32'hFFFF_FFFF;
            arg_max     <= 32'hFFFF_FFFF;
        end else if (mmio_wr) begin
            case (off)
                8'h00: begin
                    ctrl_enable <= bus.wdata[0];
                    ctrl_nonce  <= bus.wdata[1];
                end
                8'h04: opc_allow <= bus.wdata[15:0];
                8'h08: tgt_lo    <= bus.wdata;
                8'h0C: tgt_hi    <= bus.wdata;
                8'h10: arg_max   <= bus.wdata;
                default: ;
            endcase
        end
    end

    // A clear on the same edge as an increment wins.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else begin
            if (inc_acc && (accept_cnt != CNT_MAX))
                accept_cnt <= accept_cnt + 1'b1;
            if (inc_rej && (reject_cnt != CNT_MAX))
                reject_cnt <= reject_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            armed            <= 1'b0;
            tmr              <= '0;
            act_ready_q      <= 1'b1;
            exec_valid_q     <= 1'b0;
            exec_opcode_q    <= '0;
            exec_target_q    <= '0;
            exec_arg0_q      <= '0;
            exec_arg1_q      <= '0;
            verdict_valid_q  <= 1'b0;
            verdict_reason_q <= 3'd0;
            last_nonce       <= '0;
            last_reason      <= 3'd0;
            lat_opcode       <= '0;
            lat_target       <= '0;
            lat_arg0         <= '0;
            lat_arg1         <= '0;
            lat_context_hash <= '0;
            lat_policy_hash  <= '0;
            lat_bounds       <= '0;
            lat_nonce        <= '0;
        end else begin
            verdict_valid_q <= 1'b0;
            // A request must be seen low before it can be taken again.
            if (accept)
                armed <= 1'b0;
            else if (!bus.act_valid)
                armed <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_opcode       <= bus.act_opcode;
                        lat_target       <= bus.act_target;
                        lat_arg0         <= bus.act_arg0;
                        lat_arg1         <= bus.act_arg1;
                        lat_context_hash <= bus.act_context_hash;
                        lat_policy_hash  <= bus.act_policy_hash;
                        lat_bounds       <= bus.act_bounds;
                        lat_nonce        <= bus.act_nonce;
                        act_ready_q      <= 1'b0;
                        state            <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (chk_reason == 3'd0) begin
                        exec_valid_q  <= 1'b1;
                        exec_opcode_q <= lat_opcode;
                        exec_target_q <= lat_target;
                        exec_arg0_q   <= lat_arg0;
                        exec_arg1_q   <= lat_arg1;
                        tmr           <= TMR_LOAD;
                        state         <= ST_EXEC;
                    end else begin
                        verdict_valid_q  <= 1'b1;
                        verdict_reason_q <= chk_reason;
                        last_reason      <= chk_reason;
                        state            <= ST_DONE;
                    end
                end
                ST_EXEC: begin
                    if (bus.exec_ready) begin
                        exec_valid_q     <= 1'b0;
                        last_nonce       <= lat_nonce;
                        verdict_valid_q  <= 1'b1;
                        verdict_reason_q <= 3'd0;
                        last_reason      <= 3'd0;
                        state            <= ST_DONE;
                    end else if (tmr == '0) begin
                        exec_valid_q     <= 1'b0;
                        verdict_valid_q  <= 1'b1;
                        verdict_reason_q <= 3'd6;
                        last_reason      <= 3'd6;
                        state            <= ST_DONE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_DONE: begin
                    act_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_c = 32'h0;
        case (off)
            8'h00: rdata_c = {30'b0, ctrl_nonce, ctrl_enable};
            8'h04: rdata_c = {16'b0, opc_allow};
            8'h08: rdata_c = tgt_lo;
            8'h0C: rdata_c = tgt_hi;
            8'h10: rdata_c = arg_max;
            8'h14: rdata_c = {21'b0, last_reason, 6'b0, state};
            8'h18: rdata_c = 32'(accept_cnt);
            8'h1C: rdata_c = 32'(reject_cnt);
            default: rdata_c = 32'h0;
        endcase
    end

    assign bus.rdata          = rdata_c;
    assign bus.ack            = bus.sel;
    assign bus.act_ready      = act_ready_q;
    assign bus.exec_valid     = exec_valid_q;
    assign bus.exec_opcode    = exec_opcode_q;
    assign bus.exec_target    = exec_target_q;
    assign bus.exec_arg0      = exec_arg0_q;
    assign bus.exec_arg1      = exec_arg1_q;
    assign bus.verdict_valid  = verdict_valid_q;
    assign bus.verdict_reason = verdict_reason_q;

endmodule

// File: tb/tb_boreal_action_gate.sv
// Bench for boreal_action_gate: vector table, corner-case sequences and
// randomized requests against a transaction-level policy model.
module tb_boreal_action_gate;
    localparam int TO   = 16;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    boreal_action_gate_if bus();
    boreal_action_gate #(.EXEC_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    bit          m_en, m_nc;
    logic [15:0] m_allow;
    logic [31:0] m_lo, m_hi, m_argmax, m_last_nonce;
    int          m_acc, m_rej;
    logic [2:0]  m_last_reason;

    typedef struct {
        logic [31:0] op, tgt, a0, nonce;
        int          dly;
        logic [2:0]  exp_r;
        int          exp_low;
    } vec_t;
    vec_t vecs[11];

    typedef struct { logic [7:0] off; logic [31:0] val; } rd_t;
    rd_t rst_regs[9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset;
        m_en = 0; m_nc = 0; m_allow = 16'h0;
        m_lo = 32'h0; m_hi = 32'hFFFFFFFF; m_argmax = 32'hFFFFFFFF;
        m_acc = 0; m_rej = 0; m_last_nonce = 0; m_last_reason = 3'd0;
    endtask

    function automatic logic [2:0] model_reason(input logic [31:0] op, tgt, a0, nonce);
        if (!m_en) return 3'd1;
        if (op > 15 || m_allow[op[3:0]] == 1'b0) return 3'd2;
        if (tgt < m_lo || tgt > m_hi) return 3'd3;
        if (a0 > m_argmax) return 3'd4;
        if (m_nc && nonce <= m_last_nonce) return 3'd5;
        return 3'd0;
    endfunction

    task automatic mmio_write(input logic [7:0] off, input logic [31:0] d);
        bus.sel = 1; bus.wr = 1; bus.addr = {24'h0, off}; bus.wdata = d;
        tick;
        bus.sel = 0; bus.wr = 0;
        case (off)
            8'h00: begin
                m_en = d[0]; m_nc = d[1];
                if (d[2]) begin m_acc = 0; m_rej = 0; end
            end
            8'h04: m_allow = d[15:0];
            8'h08: m_lo = d;
            8'h0C: m_hi = d;
            8'h10: m_argmax = d;
            default: ;
        endcase
    endtask

    task automatic mmio_read(input logic [7:0] off, output logic [31:0] d);
        bus.sel = 1; bus.wr = 0; bus.addr = {24'h0, off};
        #1;
        d = bus.rdata;
        bus.sel = 0;
    endtask

    task automatic check_counters(input string tag);
        logic [31:0] d;
        mmio_read(8'h18, d); chk($sformatf("%s accept_cnt", tag), d, 32'(m_acc));
        mmio_read(8'h1C, d); chk($sformatf("%s reject_cnt", tag), d, 32'(m_rej));
        mmio_read(8'h14, d); chk($sformatf("%s status", tag), d, 32'(m_last_reason) << 8);
    endtask

    task automatic set_fields(input logic [31:0] op, tgt, a0, nonce);
        bus.act_opcode = op; bus.act_target = tgt; bus.act_arg0 = a0; bus.act_nonce = nonce;
        bus.act_arg1 = $urandom; bus.act_context_hash = $urandom;
        bus.act_policy_hash = $urandom; bus.act_bounds = $urandom;
    endtask

    // Arm with a low cycle, raise the request; returns just after the accept edge.
    task automatic start_req(input logic [31:0] op, tgt, a0, nonce, input logic rdy);
        bus.act_valid = 0; bus.exec_ready = rdy;
        tick;
        set_fields(op, tgt, a0, nonce);
        bus.act_valid = 1;
        tick;
    endtask

    task automatic run_txn(input string tag, input logic [31:0] op, tgt, a0, nonce,
                           input int dly, input logic [2:0] exp_r, input int exp_low);
        int low = 0, ev = 0, vcnt = 0, guard = 0;
        bit done = 0, fields_ok = 1;
        logic [2:0] got_r = 3'd7;
        logic [31:0] a1;
        bus.act_valid = 0; bus.exec_ready = 0;
        tick;
        set_fields(op, tgt, a0, nonce);
        a1 = bus.act_arg1;
        bus.act_valid = 1;
        while (!done && guard < 200) begin
            tick;
            guard++;
            if (!bus.act_ready) low++;
            if (bus.exec_valid) begin
                ev++;
                if (bus.exec_opcode !== op || bus.exec_target !== tgt ||
                    bus.exec_arg0 !== a0 || bus.exec_arg1 !== a1) fields_ok = 0;
            end
            if (bus.verdict_valid) begin vcnt++; got_r = bus.verdict_reason; end
            if (vcnt > 0 && bus.act_ready) done = 1;
            bus.exec_ready = (ev > dly);
        end
        bus.act_valid = 0; bus.exec_ready = 0;
        chk($sformatf("%s completed", tag), 32'(done), 32'd1);
        chk($sformatf("%s reason", tag), 32'(got_r), 32'(exp_r));
        chk($sformatf("%s verdict_pulses", tag), vcnt, 1);
        chk($sformatf("%s act_ready_low", tag), low, exp_low);
        chk($sformatf("%s exec_valid_cycles", tag), ev, exp_low - 2);
        chk($sformatf("%s exec_fields", tag), 32'(fields_ok), 32'd1);
        if (exp_r == 3'd0) begin
            m_acc = sat_inc(m_acc);
            m_last_nonce = nonce;
        end else begin
            m_rej = sat_inc(m_rej);
        end
        m_last_reason = exp_r;
        check_counters(tag);
    endtask

    task automatic load_policy;
        mmio_write(8'h00, 32'h1);
        mmio_write(8'h04, 32'h0004);
        mmio_write(8'h08, 32'h100);
        mmio_write(8'h0C, 32'h1FF);
        mmio_write(8'h10, 32'h40);
    endtask

    initial begin
        logic [31:0] d;
        int low;
        vecs[0]  = '{32'h2,  32'h150, 32'h5,  32'h1,  0,  3'd0, 3};
        vecs[1]  = '{32'h3,  32'h150, 32'h5,  32'h2,  0,  3'd2, 2};
        vecs[2]  = '{32'h12, 32'h150, 32'h5,  32'h3,  0,  3'd2, 2};
        vecs[3]  = '{32'h2,  32'hFF,  32'h5,  32'h4,  0,  3'd3, 2};
        vecs[4]  = '{32'h2,  32'h100, 32'h5,  32'h5,  2,  3'd0, 5};
        vecs[5]  = '{32'h2,  32'h1FF, 32'h0,  32'h6,  0,  3'd0, 3};
        vecs[6]  = '{32'h2,  32'h200, 32'h41, 32'h7,  0,  3'd3, 2};
        vecs[7]  = '{32'h2,  32'h150, 32'h40, 32'h8,  0,  3'd0, 3};
        vecs[8]  = '{32'h2,  32'h150, 32'h41, 32'h9,  0,  3'd4, 2};
        vecs[9]  = '{32'h2,  32'h150, 32'h5,  32'hA,  16, 3'd6, 18};
        vecs[10] = '{32'h2,  32'h150, 32'h5,  32'hB,  15, 3'd0, 18};
        rst_regs[0] = '{8'h00, 32'h0};
        rst_regs[1] = '{8'h04, 32'h0};
        rst_regs[2] = '{8'h08, 32'h0};
        rst_regs[3] = '{8'h0C, 32'hFFFFFFFF};
        rst_regs[4] = '{8'h10, 32'hFFFFFFFF};
        rst_regs[5] = '{8'h14, 32'h0};
        rst_regs[6] = '{8'h18, 32'h0};
        rst_regs[7] = '{8'h1C, 32'h0};
        rst_regs[8] = '{8'h20, 32'h0};

        bus.sel = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0;
        bus.act_valid = 0; bus.exec_ready = 0;
        set_fields(0, 0, 0, 0);
        model_reset();
        rst = 1;
        tick; tick;
        rst = 0;

        chk("rst act_ready", 32'(bus.act_ready), 32'd1);
        chk("rst exec_valid", 32'(bus.exec_valid), 32'd0);
        chk("rst exec_opcode", bus.exec_opcode, 32'd0);
        chk("rst verdict_valid", 32'(bus.verdict_valid), 32'd0);
        chk("rst verdict_reason", 32'(bus.verdict_reason), 32'd0);
        foreach (rst_regs[i]) begin
            mmio_read(rst_regs[i].off, d);
            chk($sformatf("rst reg %h", rst_regs[i].off), d, rst_regs[i].val);
        end
        bus.sel = 1; #1; chk("ack high", 32'(bus.ack), 32'd1);
        bus.sel = 0; #1; chk("ack low", 32'(bus.ack), 32'd0);

        mmio_write(8'h20, 32'hDEADBEEF);
        mmio_read(8'h20, d);  chk("unmapped read", d, 32'h0);
        mmio_write(8'h00, 32'hFFFFFFFF);
        mmio_read(8'h00, d);  chk("ctrl readback", d, 32'h3);

        load_policy();
        mmio_read(8'h0C, d);  chk("tgt_hi readback", d, 32'h1FF);
        mmio_read(8'h04, d);  chk("opc_allow readback", d, 32'h0004);

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].tgt, vecs[i].a0,
                    vecs[i].nonce, vecs[i].dly, vecs[i].exp_r, vecs[i].exp_low);

        // Disabled gate reports reason 1 ahead of bad opcode and target.
        mmio_write(8'h00, 32'h0);
        run_txn("prio_disabled", 32'h17, 32'h900, 32'h999, 32'h0, 0, 3'd1, 2);
        mmio_write(8'h00, 32'h1);

        // Policy write on the CHECK edge: old allow-mask still applies.
        start_req(32'h3, 32'h150, 32'h1, 32'h0, 1'b0);
        mmio_write(8'h04, 32'h0008);
        chk("late_policy verdict_valid", 32'(bus.verdict_valid), 32'd1);
        chk("late_policy reason", 32'(bus.verdict_reason), 32'd2);
        tick;
        bus.act_valid = 0;
        m_rej = sat_inc(m_rej); m_last_reason = 3'd2;
        check_counters("late_policy");
        run_txn("new_policy", 32'h3, 32'h150, 32'h1, 32'h0, 0, 3'd0, 3);

        for (int i = 0; i < 16; i++)
            run_txn($sformatf("sat%0d", i), 32'h13, 32'h150, 32'h1, 32'h0, 0, 3'd2, 2);
        mmio_read(8'h1C, d);  chk("reject_cnt saturated", d, 32'(CMAX));

        // Clear-counters on the same edge as a reject increment.
        start_req(32'h13, 32'h150, 32'h1, 32'h0, 1'b0);
        mmio_write(8'h00, 32'h5);
        chk("clear_race verdict_valid", 32'(bus.verdict_valid), 32'd1);
        tick;
        bus.act_valid = 0;
        m_last_reason = 3'd2;
        check_counters("clear_race");
        mmio_read(8'h00, d);  chk("ctrl clear reads 0", d, 32'h1);

        // Request held high after completion is not accepted twice.
        start_req(32'h3, 32'h150, 32'h1, 32'h0, 1'b1);
        tick; tick; tick;
        chk("held act_ready back", 32'(bus.act_ready), 32'd1);
        bus.exec_ready = 0;
        low = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (!bus.act_ready) low++;
        end
        chk("held no reaccept", low, 0);
        m_acc = sat_inc(m_acc); m_last_reason = 3'd0;
        check_counters("held");
        bus.act_valid = 0; tick;
        bus.act_valid = 1; bus.exec_ready = 1; tick;
        chk("rearm accepted", 32'(bus.act_ready), 32'd0);
        tick; tick; tick;
        bus.act_valid = 0; bus.exec_ready = 0;
        m_acc = sat_inc(m_acc);
        check_counters("rearm");

        // Reset during EXEC discards the action without a verdict.
        start_req(32'h3, 32'h150, 32'h1, 32'h0, 1'b0);
        tick;
        chk("pre_rst exec_valid", 32'(bus.exec_valid), 32'd1);
        tick; tick;
        rst = 1;
        tick;
        rst = 0;
        chk("mid_rst exec_valid", 32'(bus.exec_valid), 32'd0);
        chk("mid_rst act_ready", 32'(bus.act_ready), 32'd1);
        chk("mid_rst verdict_valid", 32'(bus.verdict_valid), 32'd0);
        model_reset();
        check_counters("mid_rst");
        low = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (!bus.act_ready) low++;
        end
        chk("mid_rst no accept", low, 0);
        bus.act_valid = 0;

        load_policy();
        mmio_write(8'h00, 32'h3);
        run_txn("nonce7a", 32'h2, 32'h150, 32'h1, 32'd7, 0, 3'd0, 3);
        run_txn("nonce7b", 32'h2, 32'h150, 32'h1, 32'd7, 0, 3'd5, 2);
        run_txn("nonce8a", 32'h2, 32'h150, 32'h1, 32'd8, 0, 3'd0, 3);
        run_txn("nonce8b", 32'h2, 32'h150, 32'h1, 32'd8, 0, 3'd5, 2);
        run_txn("nonce9",  32'h2, 32'h150, 32'h1, 32'd9, 1, 3'd0, 4);

        for (int i = 0; i < 48; i++) begin
            logic [31:0] op, tgt, a0, nonce;
            logic [2:0]  r;
            int          dly, sel;
            if (i % 12 == 0) begin
                logic [31:0] lo;
                lo = $urandom_range(1, 100);
                mmio_write(8'h00, {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)});
                mmio_write(8'h04, $urandom);
                mmio_write(8'h08, lo);
                mmio_write(8'h0C, lo + $urandom_range(0, 200));
                mmio_write(8'h10, $urandom_range(0, 50));
            end
            op  = $urandom_range(0, 20);
            sel = $urandom_range(0, 4);
            tgt = (sel == 0) ? m_lo - 1 : (sel == 1) ? m_lo : (sel == 2) ? m_hi :
                  (sel == 3) ? m_hi + 1 : $urandom_range(0, 400);
            sel = $urandom_range(0, 2);
            a0  = (sel == 0) ? m_argmax : (sel == 1) ? m_argmax + 1 : $urandom_range(0, 60);
            sel = $urandom_range(0, 2);
            nonce = (sel == 0) ? m_last_nonce : (sel == 1) ? m_last_nonce + 1 : $urandom_range(0, 20);
            dly = $urandom_range(0, 18);
            r = model_reason(op, tgt, a0, nonce);
            if (r == 3'd0 && dly >= TO) r = 3'd6;
            run_txn($sformatf("rnd%0d", i), op, tgt, a0, nonce, dly, r,
                    (r == 3'd0) ? dly + 3 : (r == 3'd6) ? TO + 2 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boreal_action_gate.md
Name: boreal_action_gate

Overview:
Gate-side responder for the Decision VM action-request interface. It accepts one action at a time over the valid / ready-drop / ready-rise handshake and checks it against MMIO-programmed policy (enable, opcode allow-mask, target window, arg0 ceiling, nonce replay). Passing actions go to the executor over a valid/ready port with a timeout; failing actions are dropped and logged. It sits between boreal_decision_vm and the actuator/executor fabric, and its policy registers live on the MMIO bus.

Parameters:
EXEC_TIMEOUT, 256, max cycles exec_valid is held without exec_ready before abort (>=1)
CNT_W, 32, width of accept/reject counters (<=32)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sel  in  1  MMIO select
wr  in  1  MMIO write strobe
addr  in  32  MMIO address; addr[7:0] decoded
wdata  in  32  MMIO write data
rdata  out  32  MMIO read data, combinational
ack  out  1  MMIO ack, combinational = sel
act_valid  in  1  action request valid from VM
act_opcode, act_target, act_arg0, act_arg1, act_context_hash, act_policy_hash, act_bounds, act_nonce  in  32 each  action fields
act_ready  out  1  high = idle and able to accept; low = busy
exec_valid  out  1  approved action to executor
exec_opcode, exec_target, exec_arg0, exec_arg1  out  32 each  approved action fields
exec_ready  in  1  executor accepts
verdict_valid  out  1  one-cycle pulse when a request completes
verdict_reason  out  3  reason code, valid with verdict_valid

Behaviour:
- One clock; reset is synchronous and active-high. All state is updated on posedge clk; rst takes priority over every other input.
- Reset values:
  - act_ready=1; exec_valid=0; exec_* fields=0; verdict_valid=0; verdict_reason=0.
  - state=IDLE; armed=0; counters=0; last_nonce=0; last_reason=0.
  - CTRL=0; OPC_ALLOW=0; TGT_LO=0; TGT_HI=FFFFFFFF; ARG_MAX=FFFFFFFF.
- MMIO map (offset addr[7:0]):
  - 00 CTRL R/W: bit0 enable, bit1 nonce_check; bit2 clear_counters (write-1, self-clearing, reads 0).
  - 04 OPC_ALLOW R/W [15:0].
  - 08 TGT_LO R/W; 0C TGT_HI R/W; 10 ARG_MAX R/W.
  - 14 STATUS R: {21'b0, last_reason[2:0] at [10:8], 6'b0, state[1:0]}.
  - 18 ACCEPT_CNT R; 1C REJECT_CNT R.
  - Unmapped offsets read 0; writes to them are ignored.
  - A policy write takes effect on the next edge. A CHECK evaluated on the same edge uses the old values.
- armed: set on any cycle where act_valid==0 is sampled; cleared on accept. Consequence: a request held high after completion is never accepted twice.
- FSM states: IDLE=0, CHECK=1, EXEC=2, DONE=3.
  - IDLE: act_ready=1. If armed && act_valid: latch all 8 act_* fields, act_ready<=0, go to CHECK.
  - CHECK (1 cycle): compute the reason. The lowest-numbered failing check wins:
    - 1 = enable==0
    - 2 = opcode>15, or OPC_ALLOW[opcode[3:0]]==0
    - 3 = target<TGT_LO or target>TGT_HI (unsigned, inclusive)
    - 4 = arg0>ARG_MAX (unsigned)
    - 5 = nonce_check && nonce<=last_nonce
    - 0 = pass
  - CHECK outcome: on pass, exec_valid<=1, drive exec_* from the latched fields, clear the timeout counter, go to EXEC. On fail, REJECT_CNT++, verdict_valid<=1 with the reason, go to DONE.
  - EXEC: exec_* fields are held stable.
    - exec_ready sampled 1: exec_valid<=0, ACCEPT_CNT++, last_nonce<=latched nonce, verdict (reason 0), go to DONE.
    - Otherwise the counter increments. When it reaches EXEC_TIMEOUT-1 without exec_ready: exec_valid<=0, REJECT_CNT++, verdict reason 6, go to DONE.
  - DONE (1 cycle): act_ready<=1, go to IDLE.
- act_ready is low for exactly 2 cycles on reject and 2+k cycles on the exec path, where k = cycles spent in EXEC (k>=1). This is always at least one VM sample edge.
- last_reason is updated with every verdict.
- Counters saturate at all-ones. If clear_counters and an increment coincide, clear wins.
- rst while in EXEC: exec_valid drops immediately (next edge); the pending action is discarded and no verdict is issued.

Test Plan:
- Accept: enable=1, OPC_ALLOW=0004, TGT 100..1FF; request opcode 2, target 150, arg0 5; exec_ready=1 -> exec_valid high 1 cycle with matching fields; verdict 0; ACCEPT_CNT=1; act_ready low exactly 3 cycles.
- Opcode reject: same policy; opcode 3, then opcode 0x12 -> exec_valid never asserted; reason 2 both times; REJECT_CNT=2; act_ready low exactly 2 cycles each.
- Priority: enable=0 with bad opcode and target -> reason 1. Enable=1, target 0x200, arg0 > ARG_MAX -> reason 3.
- Timeout: EXEC_TIMEOUT=16, exec_ready held 0 -> exec_valid high exactly 16 cycles, then reason 6; REJECT_CNT++; then back in IDLE.
- Nonce: nonce_check=1; nonces 7, 7, 8 -> reasons 0, 5, 0; last_nonce=8.
- Handshake/reset:
  - act_valid held high through DONE -> no second accept until act_valid is sampled low.
  - rst asserted mid-EXEC -> next cycle exec_valid=0, act_ready=1, counters 0, and a still-high act_valid is not accepted.
